// File: rtl/dmux4_buf.sv
// rtl/dmux4_buf.sv - registered 1-to-4 demultiplexer with one-entry valid/ready output buffers
// Optional feature macro: DMUX4_STALL_CNT_EN (adds STALL_CNT, a saturating source-stall counter)

module dmux4_buf #(
  parameter int N      = 32,
  parameter int DPFLAG = 1,
  parameter     GROUP  = "dpath1"
) (
  input  logic         CLK,
  input  logic         NRESET,
  input  logic [N-1:0] IN,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic         S0,
  input  logic         S1,
  output logic [N-1:0] OUT0,
  output logic [N-1:0] OUT1,
  output logic [N-1:0] OUT2,
  output logic [N-1:0] OUT3,
  output logic         VALID0,
  output logic         VALID1,
  output logic         VALID2,
  output logic         VALID3,
  input  logic         READY0,
  input  logic         READY1,
  input  logic         READY2,
  input  logic         READY3
`ifdef DMUX4_STALL_CNT_EN
  ,
  output logic [15:0]  STALL_CNT
`endif
);

  // DPFLAG and GROUP only carry placement hints for layout tools; no logic depends on them.
  if (DPFLAG == 0 && GROUP == "") begin : g_no_placement_hint
  end

  logic [1:0]        sel;
  logic              sel_ok;
  logic [3:0]        ready_vec;
  logic [3:0]        load_vec;
  logic [3:0]        valid_q, valid_d;
  logic [3:0][N-1:0] out_q, out_d;

  assign sel       = {S1, S0};
  assign ready_vec = {READY3, READY2, READY1, READY0};

  // An unknown select must never admit a word, so it forces IN_READY low.
  assign sel_ok = !$isunknown(sel);

  // Accept when the selected buffer is empty or is being drained this same cycle.
  assign IN_READY = sel_ok && (!valid_q[sel] || ready_vec[sel]);

  // Per-channel next state: a load wins over a drain, so a drained+loaded buffer stays full.
  always_comb begin
    load_vec = '0;
    valid_d  = valid_q;
    out_d    = out_q;
    for (int k = 0; k < 4; k++) begin
      load_vec[k] = IN_VALID && IN_READY && (sel == 2'(k));
      if (load_vec[k]) begin
        valid_d[k] = 1'b1;
        out_d[k]   = IN;
      end else if (valid_q[k] && ready_vec[k]) begin
        valid_d[k] = 1'b0;
      end
    end
  end

  // Output buffer registers; reset discards every buffered word.
  always_ff @(posedge CLK or negedge NRESET) begin
    if (!NRESET) begin
      valid_q <= '0;
      out_q   <= '0;
    end else begin
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  assign OUT0   = out_q[0];
  assign OUT1   = out_q[1];
  assign OUT2   = out_q[2];
  assign OUT3   = out_q[3];
  assign VALID0 = valid_q[0];
  assign VALID1 = valid_q[1];
  assign VALID2 = valid_q[2];
  assign VALID3 = valid_q[3];

`ifdef DMUX4_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where the source offers a word that cannot be taken; stick at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (IN_VALID && !IN_READY && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge CLK or negedge NRESET) begin
    if (!NRESET) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dmux4_buf.sv
// tb/tb_dmux4_buf.sv - scoreboard testbench for dmux4_buf with randomized and directed traffic

module tb_dmux4_buf;

  logic        clk = 1'b0;
  logic        nreset;
  logic [31:0] in_d;
  logic        in_valid;
  logic        in_ready;
  logic        s0, s1;
  logic [31:0] out0, out1, out2, out3;
  logic        valid0, valid1, valid2, valid3;
  logic [3:0]  r_drv;
`ifdef DMUX4_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  dmux4_buf #(.N(32), .DPFLAG(1), .GROUP("dpath1")) dut (
    .CLK(clk), .NRESET(nreset),
    .IN(in_d), .IN_VALID(in_valid), .IN_READY(in_ready),
    .S0(s0), .S1(s1),
    .OUT0(out0), .OUT1(out1), .OUT2(out2), .OUT3(out3),
    .VALID0(valid0), .VALID1(valid1), .VALID2(valid2), .VALID3(valid3),
    .READY0(r_drv[0]), .READY1(r_drv[1]), .READY2(r_drv[2]), .READY3(r_drv[3])
`ifdef DMUX4_STALL_CNT_EN
    , .STALL_CNT(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] out_a [4];
  logic [3:0]  valid_a;
  assign out_a[0] = out0;
  assign out_a[1] = out1;
  assign out_a[2] = out2;
  assign out_a[3] = out3;
  assign valid_a  = {valid3, valid2, valid1, valid0};

  int          checks = 0;
  int          errors = 0;
  bit          in_reset = 1'b1;
  logic [31:0] exp_q [4][$];
  bit          occ [4];
  logic [15:0] stall_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      exp_q[k].delete();
      occ[k] = 1'b0;
    end
    stall_m = 16'd0;
  endtask

  // One clock of stimulus; the model decides acceptance from the channel occupancy rules.
  task automatic cycle(input logic [31:0] d, input logic v, input logic [1:0] s,
                       input bit sx, input logic [3:0] r);
    logic       ok;
    logic [1:0] sel;
    logic       exp_rdy;
    @(negedge clk);
    in_d     = d;
    in_valid = v;
    s1       = s[1];
    s0       = sx ? 1'bx : s[0];
    r_drv    = r;
    #2;
    sel     = {s1, s0};
    ok      = !$isunknown(sel);
    exp_rdy = ok ? (!occ[sel] || r[sel]) : 1'b0;
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
`ifdef DMUX4_STALL_CNT_EN
    check("stall_cnt", {16'd0, stall_cnt}, {16'd0, stall_m});
    if (v && !exp_rdy && stall_m != 16'hFFFF) stall_m = stall_m + 16'd1;
`endif
    for (int k = 0; k < 4; k++) begin
      if (occ[k] && r[k]) occ[k] = 1'b0;
    end
    if (v && exp_rdy) begin
      occ[sel] = 1'b1;
      exp_q[sel].push_back(d);
    end
  endtask

  task automatic reset_for(input int n);
    @(negedge clk);
    nreset   = 1'b0;
    in_valid = 1'b1;
    in_reset = 1'b1;
    model_clear();
    repeat (n) @(negedge clk);
    nreset   = 1'b1;
    in_valid = 1'b0;
    r_drv    = 4'b0000;
    in_reset = 1'b0;
  endtask

  // Monitor: every visible word must be the oldest expected one, taken exactly once.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (in_reset) begin
        check("rst_valid", {28'd0, valid_a}, 32'd0);
        for (int k = 0; k < 4; k++) check($sformatf("rst_out%0d", k), out_a[k], 32'd0);
`ifdef DMUX4_STALL_CNT_EN
        check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
      end else begin
        for (int k = 0; k < 4; k++) begin
          check($sformatf("valid%0d", k), {31'd0, valid_a[k]},
                {31'd0, exp_q[k].size() != 0});
          if (valid_a[k] && r_drv[k]) begin
            if (exp_q[k].size() == 0) begin
              check($sformatf("unexpected_out%0d", k), out_a[k], 32'hxxxx_xxxx);
            end else begin
              check($sformatf("out%0d", k), out_a[k], exp_q[k].pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset   = 1'b0;
    in_valid = 1'b1;
    in_d     = 32'hFFFF_FFFF;
    s0       = 1'b0;
    s1       = 1'b0;
    r_drv    = 4'b0000;
    model_clear();
    repeat (3) @(negedge clk);
    nreset   = 1'b1;
    in_valid = 1'b0;
    in_reset = 1'b0;

    // Stall on a full channel 2, then drain-and-load in one cycle.
    cycle(32'hDEAD_BEEF, 1'b1, 2'd2, 1'b0, 4'b0000);
    repeat (3) cycle(32'h1234_5678, 1'b1, 2'd2, 1'b0, 4'b0000);
    cycle(32'hCAFE_0001, 1'b1, 2'd2, 1'b0, 4'b0100);
    cycle(32'd0, 1'b0, 2'd2, 1'b0, 4'b0100);

    // Back-to-back words through channel 1.
    for (int i = 1; i <= 3; i++) cycle(32'(i), 1'b1, 2'd1, 1'b0, 4'b0010);
    cycle(32'd0, 1'b0, 2'd1, 1'b0, 4'b0010);

    // Fill all four, then drain all four together.
    for (int k = 0; k < 4; k++) cycle(32'(10 + k), 1'b1, 2'(k), 1'b0, 4'b0000);
    cycle(32'd0, 1'b0, 2'd0, 1'b0, 4'b1111);
    cycle(32'd0, 1'b0, 2'd0, 1'b0, 4'b0000);

    // Unknown select bit.
    repeat (3) cycle(32'h5555_AAAA, 1'b1, 2'd0, 1'b1, 4'b0000);

    // Sustained source stall on a full channel 3.
    cycle(32'h0000_0033, 1'b1, 2'd3, 1'b0, 4'b0000);
    repeat (5) cycle(32'h0000_0034, 1'b1, 2'd3, 1'b0, 4'b0000);
    cycle(32'd0, 1'b0, 2'd3, 1'b0, 4'b1111);

    // Reset with words buffered.
    cycle(32'h0BAD_F00D, 1'b1, 2'd0, 1'b0, 4'b0000);
    cycle(32'h0BAD_F00E, 1'b1, 2'd1, 1'b0, 4'b0000);
    reset_for(2);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom, 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)));
      if (i == 300) reset_for(1);
    end

    // Drain everything and confirm nothing is left outstanding.
    repeat (3) cycle(32'd0, 1'b0, 2'd0, 1'b0, 4'b1111);
    @(negedge clk);
    #3;
    for (int k = 0; k < 4; k++) check($sformatf("leftover%0d", k), exp_q[k].size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
